// File: rtl/cdb_arbiter_pkg.sv
// Shared LC-3b CDB types, requester count and a small request-count helper.
package cdb_arbiter_pkg;

  localparam int NUM_RS_UNITS = 4;
  localparam int NUM_CDB_REQ  = NUM_RS_UNITS + 1;
  localparam int ROB_ADDR_W   = 3;

  typedef logic [ROB_ADDR_W-1:0] lc3b_rob_addr;
  typedef logic [15:0]           lc3b_word;

  typedef struct packed {
    logic         valid;
    lc3b_rob_addr tag;
    lc3b_word     value;
  } cdb_t;

  // True when two or more bits are set (clearing the lowest set bit leaves something).
  function automatic logic multi_req(input logic [7:0] r);
    return (r & (r - 8'd1)) != 8'd0;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo N.
module rr_picker #(
  parameter int N     = 5,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx
);

  int               c;
  logic [PTR_W-1:0] ci;
  logic             found;

  // Scan offsets from far to near so the nearest request to ptr is written last and wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    ci    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      ci = PTR_W'(c);
      if (req[ci]) begin
        idx   = ci;
        found = 1'b1;
      end
    end
    if (found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one broadcast per cycle, registered one cycle after grant.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ  = NUM_CDB_REQ,
  parameter int ROB_W  = $bits(lc3b_rob_addr),
  parameter int DATA_W = $bits(lc3b_word)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ROB_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_value,
  output logic [N_REQ-1:0]        gnt,
  output logic                    cdb_valid,
  output logic [ROB_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_value,
  output logic [15:0]             conflict_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] nxt_ptr;
  logic [N_REQ-1:0] pick_gnt;
  logic [PTR_W-1:0] pick_idx;
  logic             grant_any;
  logic             conflict;

  rr_picker #(.N(N_REQ), .PTR_W(PTR_W)) u_picker (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Flush and reset both silence the grant so no requester frees its slot.
  assign gnt       = (rst_n && !flush) ? pick_gnt : '0;
  assign grant_any = |gnt;
  assign nxt_ptr   = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
  assign conflict  = !flush && multi_req(8'(req));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid    <= 1'b0;
      cdb_tag      <= '0;
      cdb_value    <= '0;
      conflict_cnt <= '0;
      rr_ptr       <= '0;
    end else begin
      if (grant_any) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= req_tag[pick_idx*ROB_W +: ROB_W];
        cdb_value <= req_value[pick_idx*DATA_W +: DATA_W];
        rr_ptr    <= nxt_ptr;
      end else begin
        cdb_valid <= 1'b0;
      end
      if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed grant/flush/reset vectors, random fairness, counter saturation.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 5;
  localparam int RW = 3;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*RW-1:0] req_tag = '0;
  logic [N*DW-1:0] req_value = '0;
  logic [N-1:0]    gnt;
  logic            cdb_valid;
  logic [RW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_value;
  logic [15:0]     conflict_cnt;

  cdb_arbiter #(.N_REQ(N), .ROB_W(RW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .req          (req),
    .req_tag      (req_tag),
    .req_value    (req_value),
    .gnt          (gnt),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_value    (cdb_value),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  cdb_t        exp_q[$];
  bit          sb_en = 1'b1;
  logic [15:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic cdb_t ent(input logic [RW-1:0] t, input logic [DW-1:0] v);
    cdb_t e;
    e.valid = 1'b1;
    e.tag   = t;
    e.value = v;
    return e;
  endfunction

  task automatic set_src(input int i, input logic [RW-1:0] t, input logic [DW-1:0] v);
    req_tag[i*RW +: RW]   = t;
    req_value[i*DW +: DW] = v;
  endtask

  // Reference conflict counter advances on the edge that ends the current cycle.
  task automatic tick();
    if (rst_n && !flush && $countones(req) >= 2 && exp_cnt != 16'hFFFF) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    cdb_t e;
    if (rst_n && sb_en && cdb_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got tag %0h value %0h, expected no broadcast", cdb_tag, cdb_value);
      end else begin
        e = exp_q.pop_front();
        chk("sb_tag", 32'(cdb_tag), 32'(e.tag));
        chk("sb_value", 32'(cdb_value), 32'(e.value));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  int          order[7] = '{0, 1, 2, 3, 4, 0, 1};
  bit          pending[N];
  int          waitc[N];
  logic [RW-1:0] rq_tag[N];
  logic [DW-1:0] rq_val[N];
  logic [N-1:0]  g;

  initial begin
    // Reset state while a request is already presented.
    set_src(0, 3'd3, 16'h1234);
    req = 5'b00001;
    #2;
    chk("rst_valid", 32'(cdb_valid), 0);
    chk("rst_tag", 32'(cdb_tag), 0);
    chk("rst_value", 32'(cdb_value), 0);
    chk("rst_cnt", 32'(conflict_cnt), 0);
    chk("rst_gnt", 32'(gnt), 0);

    // Test 1: two broadcasts, then async reset between edges.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t1_gnt_a", 32'(gnt), 32'b00001);
    exp_q.push_back(ent(3'd3, 16'h1234));
    tick();
    chk("t1_gnt_b", 32'(gnt), 32'b00001);
    exp_q.push_back(ent(3'd3, 16'h1234));
    tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_async_valid", 32'(cdb_valid), 0);
    chk("t1_async_tag", 32'(cdb_tag), 0);
    chk("t1_async_value", 32'(cdb_value), 0);
    chk("t1_async_gnt", 32'(gnt), 0);
    req = '0;
    exp_cnt = '0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Test 3: all request from rr_ptr=0, order 0,1,2,3,4,0,1.
    for (int i = 0; i < N; i++) set_src(i, RW'(i), 16'hA000 + 16'(i));
    req = 5'b11111;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("t3_rr_gnt", 32'(gnt), 32'(1) << order[k]);
      exp_q.push_back(ent(RW'(order[k]), 16'hA000 + 16'(order[k])));
      tick();
    end
    req = '0;
    chk("t3_cnt", 32'(conflict_cnt), 7);

    // Test 2: lone requester 2 -> gnt same cycle, broadcast next cycle.
    set_src(2, 3'd5, 16'hBEEF);
    req = 5'b00100;
    #1;
    chk("t2_gnt", 32'(gnt), 32'b00100);
    exp_q.push_back(ent(3'd5, 16'hBEEF));
    tick();
    chk("t2_valid", 32'(cdb_valid), 1);
    req = 5'b01001;
    #1;
    chk("t2_ptr3_gnt", 32'(gnt), 32'b01000);
    exp_q.push_back(ent(3'd3, 16'hA003));
    tick();

    // Test 5: rr_ptr=4, req 01001 -> 0 then 3.
    #1;
    chk("t5_skip_gnt0", 32'(gnt), 32'b00001);
    exp_q.push_back(ent(3'd0, 16'hA000));
    tick();
    #1;
    chk("t5_skip_gnt3", 32'(gnt), 32'b01000);
    exp_q.push_back(ent(3'd3, 16'hA003));
    tick();
    req = '0;
    chk("t5_cnt", 32'(conflict_cnt), 10);

    // Test 4: broadcast registered, then flush collides with 10010.
    set_src(4, 3'd6, 16'hC0DE);
    req = 5'b10000;
    #1;
    chk("t4_pre_gnt", 32'(gnt), 32'b10000);
    exp_q.push_back(ent(3'd6, 16'hC0DE));
    tick();
    req = 5'b10010;
    flush = 1'b1;
    #1;
    chk("t4_flush_gnt", 32'(gnt), 0);
    chk("t4_flush_visible", 32'(cdb_valid), 1);
    tick();
    flush = 1'b0;
    req = '0;
    #1;
    chk("t4_post_valid", 32'(cdb_valid), 0);
    chk("t4_cnt_held", 32'(conflict_cnt), 10);
    req = 5'b10010;
    #1;
    chk("t4_ptr_held_gnt", 32'(gnt), 32'b00010);
    exp_q.push_back(ent(3'd1, 16'hA001));
    tick();
    req = '0;
    tick();
    tick();
    chk("directed_drained", 32'(exp_q.size()), 0);
    chk("directed_cnt", 32'(conflict_cnt), 11);

    // Random traffic: one-hot, subset of req, bounded wait.
    for (int i = 0; i < N; i++) begin
      pending[i] = 1'b0;
      waitc[i]   = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && $urandom_range(2) == 0) begin
          pending[i] = 1'b1;
          waitc[i]   = 0;
          rq_tag[i]  = RW'($urandom);
          rq_val[i]  = DW'($urandom);
        end
        req[i] = pending[i];
        set_src(i, rq_tag[i], rq_val[i]);
      end
      flush = ($urandom_range(49) == 0);
      #1;
      g = gnt;
      chk("rnd_onehot", 32'($countones(g) <= 1), 1);
      chk("rnd_subset", 32'(g & ~req), 0);
      if (flush) chk("rnd_flush_gnt", 32'(g), 0);
      for (int i = 0; i < N; i++) begin
        if (pending[i]) waitc[i]++;
        if (g[i]) begin
          n_cmp++;
          if (waitc[i] > N) begin
            n_err++;
            $display("FAIL rnd_fair: requester %0d waited %0d cycles, limit %0d", i, waitc[i], N);
          end
          exp_q.push_back(ent(rq_tag[i], rq_val[i]));
          pending[i] = 1'b0;
        end
        if (flush) pending[i] = 1'b0;
      end
      tick();
    end
    req = '0;
    flush = 1'b0;
    tick();
    tick();
    chk("rnd_drained", 32'(exp_q.size()), 0);
    chk("rnd_cnt", 32'(conflict_cnt), 32'(exp_cnt));

    // Test 6: long conflict run up to and past saturation.
    sb_en = 1'b0;
    req = 5'b11111;
    for (int i = 0; i < 70000 && exp_cnt != 16'hFFFE; i++) tick();
    chk("sat_pre", 32'(conflict_cnt), 32'hFFFE);
    tick();
    chk("sat_max", 32'(conflict_cnt), 32'hFFFF);
    tick();
    tick();
    chk("sat_hold", 32'(conflict_cnt), 32'hFFFF);
    req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
